// File: rtl/ast_mux.sv
// ast_mux: registered 2:1 multiplexer, mux_out = sel ? I1 : I0, golden reference datapath.
// Ports: clk, rst (sync, active-high); I0/I1 [WIDTH] data, sel select, in_valid qualifier;
//        mux_out [WIDTH] selected data, out_valid result qualifier;
//        mismatch sticky self-check flag, err_count [8] saturating self-check error count.
// Optional: define AST_MUX_SELFCHECK_EN to build a second sum-of-products path that is
//           compared against the primary path; otherwise mismatch and err_count are tied to 0.
module ast_mux #(
    parameter int WIDTH   = 1,
    parameter bit REG_OUT = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] I0,
    input  logic [WIDTH-1:0] I1,
    input  logic             sel,
    input  logic             in_valid,
    output logic [WIDTH-1:0] mux_out,
    output logic             out_valid,
    output logic             mismatch,
    output logic [7:0]       err_count
);
    logic [WIDTH-1:0] mux_c;
    logic [WIDTH-1:0] mux_q;
    assign mux_c = sel ? I1 : I0;
    // The primary result is always registered so the self-check has a stable value to compare.
    always_ff @(posedge clk) begin
        if (rst) begin
            mux_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) mux_q <= mux_c;
        end
    end
    assign mux_out = REG_OUT ? mux_q : mux_c;
`ifdef AST_MUX_SELFCHECK_EN
    logic [WIDTH-1:0] sop_c;
    logic [WIDTH-1:0] sop_q;
    assign sop_c = (I0 & ~{WIDTH{sel}}) | (I1 & {WIDTH{sel}});
    always_ff @(posedge clk) begin
        if (rst) begin
            sop_q     <= '0;
            mismatch  <= 1'b0;
            err_count <= 8'd0;
        end else begin
            if (in_valid) sop_q <= sop_c;
            if (out_valid && (mux_q != sop_q)) begin
                mismatch <= 1'b1;
                if (err_count != 8'hFF) err_count <= err_count + 8'd1;
            end
        end
    end
`else
    assign mismatch  = 1'b0;
    assign err_count = 8'd0;
`endif
endmodule

// File: tb/tb_ast_mux.sv
// tb_ast_mux: self-checking bench for ast_mux in three configurations against a truth-table model.
module tb_ast_mux;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       a1 = 1'b0, b1 = 1'b0, s1 = 1'b0, v1 = 1'b0;
    logic [7:0] a8 = 8'd0, b8 = 8'd0;
    logic       s8 = 1'b0, v8 = 1'b0;
    logic       a0 = 1'b0, b0 = 1'b0, s0 = 1'b0, v0 = 1'b0;
    logic       o1, ov1, mm1, o0, ov0, mm0, mm8, ov8;
    logic [7:0] o8, ec1, ec8, ec0;
    int         checks = 0;
    int         errors = 0;
    logic       chk_en1 = 1'b1;

    always #5 clk = ~clk;

    ast_mux #(.WIDTH(1), .REG_OUT(1'b1)) u1 (
        .clk(clk), .rst(rst), .I0(a1), .I1(b1), .sel(s1), .in_valid(v1),
        .mux_out(o1), .out_valid(ov1), .mismatch(mm1), .err_count(ec1));
    ast_mux #(.WIDTH(8), .REG_OUT(1'b1)) u8 (
        .clk(clk), .rst(rst), .I0(a8), .I1(b8), .sel(s8), .in_valid(v8),
        .mux_out(o8), .out_valid(ov8), .mismatch(mm8), .err_count(ec8));
    ast_mux #(.WIDTH(1), .REG_OUT(1'b0)) u0 (
        .clk(clk), .rst(rst), .I0(a0), .I1(b0), .sel(s0), .in_valid(v0),
        .mux_out(o0), .out_valid(ov0), .mismatch(mm0), .err_count(ec0));

    // Model: each output bit is looked up in the spec's WIDTH=1 truth table indexed by {I0,I1,sel}.
    function automatic logic [63:0] f(input logic [63:0] a, input logic [63:0] b, input logic s);
        logic [7:0]  tt;
        logic [63:0] r;
        tt = 8'b11011000;
        for (int i = 0; i < 64; i++) r[i] = tt[{a[i], b[i], s}];
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    logic        m_ok = 1'b0;
    logic        m1_v, m8_v, m0_v;
    logic        m1_d;
    logic [7:0]  m8_d;
    logic [63:0] t1, t8;
    always_comb begin
        t1 = f({63'd0, a1}, {63'd0, b1}, s1);
        t8 = f({56'd0, a8}, {56'd0, b8}, s8);
    end
    always @(posedge clk) begin
        if (rst) begin
            m_ok <= 1'b1;
            m1_v <= 1'b0; m1_d <= 1'b0;
            m8_v <= 1'b0; m8_d <= 8'd0;
            m0_v <= 1'b0;
        end else begin
            m1_v <= v1;
            m8_v <= v8;
            m0_v <= v0;
            if (v1) m1_d <= t1[0];
            if (v8) m8_d <= t8[7:0];
        end
    end

    logic [63:0] t0;
    always @(negedge clk) begin
        if (m_ok) begin
            t0 = f({63'd0, a0}, {63'd0, b0}, s0);
            if (chk_en1) begin
                chk("m_u1_out", {63'd0, o1}, {63'd0, m1_d});
                chk("m_u1_valid", {63'd0, ov1}, {63'd0, m1_v});
            end
            chk("m_u8_out", {56'd0, o8}, {56'd0, m8_d});
            chk("m_u8_valid", {63'd0, ov8}, {63'd0, m8_v});
            chk("m_u0_out", {63'd0, o0}, t0);
            chk("m_u0_valid", {63'd0, ov0}, {63'd0, m0_v});
            chk("m_u8_selfcheck", {55'd0, mm8, ec8}, 64'd0);
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    logic [7:0] sweep_exp;
    initial begin
        sweep_exp = 8'b11011000;
        rst = 1'b1;
        cyc();
        cyc();
        chk("rst_u1_out", {63'd0, o1}, 64'd0);
        chk("rst_u1_valid", {63'd0, ov1}, 64'd0);
        chk("rst_u1_selfcheck", {55'd0, mm1, ec1}, 64'd0);
        rst = 1'b0;
        // exhaustive sweep, expected 0,0,0,1,1,0,1,1
        for (int k = 0; k < 8; k++) begin
            {a1, b1, s1} = 3'(k);
            v1 = 1'b1;
            cyc();
            chk("sweep_out", {63'd0, o1}, {63'd0, sweep_exp[k]});
            chk("sweep_valid", {63'd0, ov1}, 64'd1);
        end
        v1 = 1'b0;
        cyc();
        chk("sweep_selfcheck", {55'd0, mm1, ec1}, 64'd0);
        // hold
        {a1, b1, s1} = 3'b100; v1 = 1'b1;
        cyc();
        chk("hold_cap", {63'd0, o1}, 64'd1);
        a1 = 1'b0; v1 = 1'b0;
        cyc();
        chk("hold_out", {63'd0, o1}, 64'd1);
        chk("hold_valid", {63'd0, ov1}, 64'd0);
        // reset mid-stream with in_valid still high
        {a1, b1, s1} = 3'b100; v1 = 1'b1;
        cyc();
        chk("mid_cap", {63'd0, o1}, 64'd1);
        rst = 1'b1; {a1, b1, s1} = 3'b011;
        cyc();
        chk("mid_rst_out", {63'd0, o1}, 64'd0);
        chk("mid_rst_valid", {63'd0, ov1}, 64'd0);
        rst = 1'b0;
        cyc();
        chk("post_rst_out", {63'd0, o1}, 64'd1);
        chk("post_rst_valid", {63'd0, ov1}, 64'd1);
        v1 = 1'b0;
        // WIDTH=8 back-to-back alternating
        a8 = 8'hA5; b8 = 8'h3C;
        for (int j = 0; j < 4; j++) begin
            s8 = j[0]; v8 = 1'b1;
            cyc();
            chk("w8_out", {56'd0, o8}, j[0] ? 64'h3C : 64'hA5);
            chk("w8_valid", {63'd0, ov8}, 64'd1);
        end
        v8 = 1'b0;
        cyc();
        chk("w8_idle_valid", {63'd0, ov8}, 64'd0);
        chk("w8_hold", {56'd0, o8}, 64'h3C);
        // combinational variant
        {a0, b0, s0} = 3'b101; v0 = 1'b1;
        #1;
        chk("comb_101", {63'd0, o0}, 64'd0);
        chk("comb_valid_lag", {63'd0, ov0}, 64'd0);
        {a0, b0, s0} = 3'b110;
        #1;
        chk("comb_110", {63'd0, o0}, 64'd1);
        cyc();
        chk("comb_valid", {63'd0, ov0}, 64'd1);
        v0 = 1'b0;
        cyc();
        chk("comb_valid_drop", {63'd0, ov0}, 64'd0);
        chk("comb_live", {63'd0, o0}, 64'd1);
`ifdef AST_MUX_SELFCHECK_EN
        // corrupt the primary path for one valid capture
        chk_en1 = 1'b0;
        {a1, b1, s1} = 3'b000; v1 = 1'b1;
        force u1.mux_c = 1'b1;
        cyc();
        release u1.mux_c;
        v1 = 1'b0;
        cyc();
        chk("inj_mismatch", {63'd0, mm1}, 64'd1);
        chk("inj_count", {56'd0, ec1}, 64'd1);
        cyc();
        cyc();
        chk("inj_sticky", {55'd0, mm1, ec1}, {55'd0, 1'b1, 8'd1});
        rst = 1'b1;
        cyc();
        chk("inj_cleared", {55'd0, mm1, ec1}, 64'd0);
        rst = 1'b0;
        chk_en1 = 1'b1;
        cyc();
`endif
        cyc();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ast_mux.md
Name: ast_mux

Overview:
- Registered 2:1 multiplexer: `mux_out = sel ? I1 : I0`, bitwise over a parameterised data width.
- Serves as the golden reference datapath that candidate (generated/evolved) mux netlists are compared against in equivalence sweeps.
- Also usable as a plain pipelined select stage.
- Single clock domain, synchronous active-high reset.

Parameters:
- WIDTH, 1, data width of I0, I1 and mux_out (legal range 1..64).
- REG_OUT, 1, 1 = output registered (1-cycle latency); 0 = combinational output path, with only out_valid registered.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous reset, active-high
- I0  input  WIDTH  data selected when sel=0
- I1  input  WIDTH  data selected when sel=1
- sel  input  1  select
- in_valid  input  1  qualifies I0/I1/sel for capture
- mux_out  output  WIDTH  selected data
- out_valid  output  1  mux_out holds a result from a valid input
- mismatch  output  1  sticky self-check failure flag (see Optional Feature)
- err_count  output  8  saturating self-check error counter (see Optional Feature)

Behaviour:
- Interface: one clock, `clk`. Reset `rst` is synchronous and active-high, sampled only on the rising edge of clk.
- Function, applied bitwise for every bit i: sel=0 → mux_out[i]=I0[i]; sel=1 → mux_out[i]=I1[i]. Full truth table for WIDTH=1 (I0,I1,sel → out):
  - 000→0, 001→0, 010→0, 011→1
  - 100→1, 101→0, 110→1, 111→1
- REG_OUT=1:
  - On a clk edge with in_valid=1 and rst=0: mux_out ← selected data; out_valid ← 1. Latency is exactly 1 cycle.
  - On a clk edge with in_valid=0: mux_out holds its previous value; out_valid ← 0.
  - Back-to-back valid inputs give one result per cycle. No backpressure and no ready signal.
- REG_OUT=0:
  - mux_out follows the inputs combinationally, with zero latency, regardless of in_valid.
  - out_valid is in_valid registered by one cycle.
- Reset (rst=1 at a clk edge): mux_out ← 0, out_valid ← 0, mismatch ← 0, err_count ← 0.
  - Reset has priority over in_valid.
  - A reset asserted mid-stream discards any in-flight result. The first valid input after rst deasserts produces out_valid one cycle later.
- Reset is not required for the function itself; with REG_OUT=0, mux_out is live during reset.
- X/Z inputs: behaviour is undefined; no X-propagation guarantees are required.

Optional Feature:
- Macro: `AST_MUX_SELFCHECK_EN`.
- Defined:
  - A second, independent implementation is built: sum-of-products `(I0 & ~{WIDTH{sel}}) | (I1 & {WIDTH{sel}})`.
  - It is registered alongside the primary path.
  - On every cycle with out_valid=1, the two registered results are compared:
    - Any bit differs → mismatch ← 1 (sticky until rst).
    - On the same mismatch condition, err_count increments, saturating at 255.
  - Both outputs are cleared only by rst.
- Undefined:
  - No second implementation is built.
  - mismatch is tied to 0 and err_count is tied to 0.
  - Port list is identical in both builds.

Test Plan:
1. Reset, then exhaustive sweep, WIDTH=1, REG_OUT=1: apply I0,I1,sel = 000..111, one per cycle with in_valid=1 → one cycle later out_valid=1 and mux_out = 0,0,0,1,1,0,1,1 in order.
2. Hold behaviour: apply I0=1, I1=0, sel=0 (in_valid=1) → mux_out=1. Then in_valid=0 with I0=0 → mux_out stays 1, out_valid=0.
3. Reset mid-stream: rst=1 in the cycle after a valid capture of mux_out=1 → next edge gives mux_out=0, out_valid=0. After deassert, input 011 → mux_out=1 one cycle later.
4. WIDTH=8: I0=8'hA5, I1=8'h3C; sel=0 → 8'hA5; sel=1 → 8'h3C. Back-to-back inputs give alternating outputs with 1-cycle latency.
5. REG_OUT=0: input 101 → mux_out=0 in the same cycle with no edge. Input 110 → mux_out=1 immediately; out_valid lags in_valid by one cycle.
6. With `AST_MUX_SELFCHECK_EN` defined: run the full 8-vector sweep → mismatch=0, err_count=0. Force one primary-path bit via bench force for one valid cycle → mismatch=1 and err_count=1, both persisting until rst.
